modulo_alimentador_rolhas: RTL and testbench

//   Cork feeder responder: serves refill requests from the tray (bandeja) logic.
//   On a request it dispenses a batch of corks as single-cycle pulses, one per cork,
//   and tracks the feeder's own stock. It completes with a 4-phase req/done handshake.
//   Its cork pulse output feeds the tray cork counter in place of the manual op_c button.

---
 rtl/modulo_alimentador_rolhas.sv | 141 ++++++++++++++
 tb/tb_modulo_alimentador_rolhas.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_alimentador_rolhas.sv
// Cork feeder responder for the tray refill logic.
// When a request arrives, the feeder sends a batch of corks as single-cycle pulses,
// with a fixed number of cycles between pulses. It keeps track of how many corks are
// left in stock and finishes the exchange with a 4-phase req/done handshake.
module modulo_alimentador_rolhas #(
    parameter int LOTE            = 20,
    parameter int ESTOQUE_INICIAL = 99,
    parameter int PERIODO_PULSO   = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       enable,
    input  logic       req,
    input  logic       recarga,
    output logic       ack,
    output logic       busy,
    output logic       rolha,
    output logic       done,
    output logic       parcial,
    output logic [6:0] estoque,
    output logic       vazio
);

    localparam int SW = $clog2(LOTE + 1);
    localparam int TW = $clog2(PERIODO_PULSO + 1);

    localparam logic [SW-1:0] LOTE_W      = SW'(LOTE);
    localparam logic [6:0]    ESTOQUE_INI = 7'(ESTOQUE_INICIAL);
    localparam logic [TW-1:0] TIMER_LOAD  = TW'(PERIODO_PULSO - 1);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_DISPENSA  = 2'd1;
    localparam logic [1:0] S_INTERVALO = 2'd2;
    localparam logic [1:0] S_FIM       = 2'd3;

    logic [1:0]    state_q,   state_d;
    logic [6:0]    estoque_q, estoque_d;
    logic [SW-1:0] sent_q,    sent_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic          ack_q,     ack_d;
    logic          busy_q,    busy_d;
    logic          rolha_q,   rolha_d;
    logic          done_q,    done_d;
    logic          parcial_q, parcial_d;
    logic [SW-1:0] sent_inc;

    assign sent_inc = sent_q + 1'b1;

    // Next-state and next-output logic. When enable is low, everything holds and the pulse outputs are forced low.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        estoque_d = estoque_q;
        sent_d    = sent_q;
        timer_d   = timer_q;
        parcial_d = parcial_q;
        ack_d     = 1'b0;
        rolha_d   = 1'b0;

        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    // A restock wins over a request in the same cycle; the request is served on the next cycle.
                    if (recarga) begin
                        estoque_d = ESTOQUE_INI;
                    end else if (req && (estoque_q != 7'd0)) begin
                        ack_d   = 1'b1;
                        sent_d  = '0;
                        state_d = S_DISPENSA;
                    end
                end
                S_DISPENSA: begin
                    rolha_d = 1'b1;
                    sent_d  = sent_inc;
                    if (estoque_q != 7'd0) begin
                        estoque_d = estoque_q - 7'd1;
                    end
                    if ((sent_inc == LOTE_W) || (estoque_q <= 7'd1)) begin
                        state_d   = S_FIM;
                        parcial_d = (sent_inc < LOTE_W);
                    end else begin
                        state_d = S_INTERVALO;
                        timer_d = TIMER_LOAD;
                    end
                end
                S_INTERVALO: begin
                    timer_d = timer_q - TIMER_ONE;
                    if (timer_q == TIMER_ONE) begin
                        state_d = S_DISPENSA;
                    end
                end
                default: begin
                    // S_FIM: keep done high until the requester releases req.
                    if (!req) begin
                        state_d   = S_IDLE;
                        parcial_d = 1'b0;
                    end
                end
            endcase
        end

        busy_d = (state_d == S_DISPENSA) || (state_d == S_INTERVALO);
        done_d = (state_d == S_FIM);
    end

    // State and output registers. clr is synchronous and takes priority over enable.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples the values from before the clock edge.
        if (clr) begin
            state_q   <= S_IDLE;
            estoque_q <= ESTOQUE_INI;
            sent_q    <= '0;
            timer_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            rolha_q   <= 1'b0;
            done_q    <= 1'b0;
            parcial_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            estoque_q <= estoque_d;
            sent_q    <= sent_d;
            timer_q   <= timer_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            rolha_q   <= rolha_d;
            done_q    <= done_d;
            parcial_q <= parcial_d;
        end
    end

    assign ack     = ack_q;
    assign busy    = busy_q;
    assign rolha   = rolha_q;
    assign done    = done_q;
    assign parcial = parcial_q;
    assign estoque = estoque_q;
    assign vazio   = (estoque_q == 7'd0);

endmodule

// File: tb/tb_modulo_alimentador_rolhas.sv
// Directed testbench for the cork feeder. Inputs change 1 time unit after each rising
// clock edge, and outputs are sampled at that same point.
module tb_modulo_alimentador_rolhas;

    logic       clk = 1'b0;
    logic       clr, enable, req, recarga;
    logic       ack, busy, rolha, done, parcial, vazio;
    logic [6:0] estoque;

    int checks = 0;
    int errors = 0;

    modulo_alimentador_rolhas dut (
        .clk     (clk),
        .clr     (clr),
        .enable  (enable),
        .req     (req),
        .recarga (recarga),
        .ack     (ack),
        .busy    (busy),
        .rolha   (rolha),
        .done    (done),
        .parcial (parcial),
        .estoque (estoque),
        .vazio   (vazio)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Keeps clocking until the requested number of pulses has been seen (when stop_at > 0),
    // until done goes high, or until the cycle budget runs out.
    task automatic wait_pulses(input int stop_at, input int max_cycles, output int pulses,
                               output int first_cyc, output int ack_cyc, output int gap_err,
                               output bit timed_out);
        int last;
        int cyc;
        pulses = 0; first_cyc = -1; ack_cyc = -1; gap_err = 0; timed_out = 1'b0;
        last = -1; cyc = 0;
        forever begin
            tick();
            cyc++;
            if (ack === 1'b1) ack_cyc = cyc;
            if (rolha === 1'b1) begin
                if (last < 0) first_cyc = cyc;
                else if (cyc - last != 4) gap_err++;
                last = cyc;
                pulses++;
            end
            if (done === 1'b1) break;
            if (stop_at > 0 && pulses == stop_at) break;
            if (cyc >= max_cycles) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; enable = 1'b0; req = 1'b0; recarga = 1'b0;
        tick();
        tick();
        checks++;
        if ({ack, busy, rolha, done, parcial} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 00000", {ack, busy, rolha, done, parcial});
        end
        checks++;
        if (estoque !== 7'd99 || vazio !== 1'b0) begin
            errors++; $display("FAIL reset_estoque: got %0d vazio=%b expected 99 vazio=0", estoque, vazio);
        end
        clr = 1'b0; enable = 1'b1;
    endtask

    task automatic test_full_batch();
        int p, fc, ac, ge;
        bit to;
        req = 1'b1;
        wait_pulses(0, 200, p, fc, ac, ge, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL t1_timeout: got %b expected 0", to); end
        checks++;
        if (ac != 1 || fc != 2) begin
            errors++; $display("FAIL t1_latency: ack at %0d rolha at %0d expected 1 and 2", ac, fc);
        end
        checks++;
        if (p != 20 || ge != 0) begin
            errors++; $display("FAIL t1_pulses: got %0d gap_err=%0d expected 20 gap_err=0", p, ge);
        end
        checks++;
        if (done !== 1'b1 || parcial !== 1'b0 || busy !== 1'b0 || estoque !== 7'd79) begin
            errors++; $display("FAIL t1_end: done=%b parcial=%b busy=%b estoque=%0d expected 1 0 0 79", done, parcial, busy, estoque);
        end
        req = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || ack !== 1'b0) begin
            errors++; $display("FAIL t1_release: done=%b busy=%b ack=%b expected 0 0 0", done, busy, ack);
        end
    endtask

    task automatic run_batch(output int pulses, output bit to);
        int fc, ac, ge;
        req = 1'b1;
        wait_pulses(0, 200, pulses, fc, ac, ge, to);
        req = 1'b0;
        tick();
    endtask

    // Starting from 79, three full batches bring the stock to 19; the next batch runs the stock out.
    task automatic test_drain();
        int p, total, fc, ac, ge, seen;
        bit to, any_to;
        total = 0; any_to = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_batch(p, to);
            total += p;
            any_to |= to;
        end
        checks++;
        if (total != 60 || any_to || estoque !== 7'd19) begin
            errors++; $display("FAIL t2_drain: pulses=%0d timeout=%b estoque=%0d expected 60 0 19", total, any_to, estoque);
        end
        req = 1'b1;
        wait_pulses(0, 200, p, fc, ac, ge, to);
        checks++;
        if (to || p != 19 || ge != 0) begin
            errors++; $display("FAIL t2_short_pulses: got %0d timeout=%b gap_err=%0d expected 19 0 0", p, to, ge);
        end
        checks++;
        if (done !== 1'b1 || parcial !== 1'b1 || vazio !== 1'b1 || estoque !== 7'd0) begin
            errors++; $display("FAIL t2_short_end: done=%b parcial=%b vazio=%b estoque=%0d expected 1 1 1 0", done, parcial, vazio, estoque);
        end
        req = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || parcial !== 1'b0) begin
            errors++; $display("FAIL t2_release: done=%b parcial=%b expected 0 0", done, parcial);
        end
        req = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack === 1'b1 || busy === 1'b1 || rolha === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || estoque !== 7'd0) begin
            errors++; $display("FAIL t2_empty_req: active cycles=%0d estoque=%0d expected 0 0", seen, estoque);
        end
        req = 1'b0; recarga = 1'b1;
        tick();
        recarga = 1'b0;
        checks++;
        if (estoque !== 7'd99 || vazio !== 1'b0) begin
            errors++; $display("FAIL t2_recarga: estoque=%0d vazio=%b expected 99 0", estoque, vazio);
        end
    endtask

    task automatic test_enable_pause();
        int p, fc, ac, ge, stray;
        bit to;
        req = 1'b1;
        wait_pulses(5, 200, p, fc, ac, ge, to);
        checks++;
        if (to || p != 5 || estoque !== 7'd94) begin
            errors++; $display("FAIL t3_first5: pulses=%0d timeout=%b estoque=%0d expected 5 0 94", p, to, estoque);
        end
        enable = 1'b0;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rolha !== 1'b0 || estoque !== 7'd94 || busy !== 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL t3_frozen: bad cycles=%0d expected 0", stray);
        end
        enable = 1'b1;
        wait_pulses(0, 200, p, fc, ac, ge, to);
        checks++;
        if (to || p != 15 || fc != 4 || ge != 0) begin
            errors++; $display("FAIL t3_resume: pulses=%0d first=%0d gap_err=%0d timeout=%b expected 15 4 0 0", p, fc, ge, to);
        end
        checks++;
        if (done !== 1'b1 || parcial !== 1'b0 || estoque !== 7'd79) begin
            errors++; $display("FAIL t3_end: done=%b parcial=%b estoque=%0d expected 1 0 79", done, parcial, estoque);
        end
        req = 1'b0;
        tick();
    endtask

    task automatic test_recarga_priority();
        int p, fc, ac, ge;
        bit to;
        run_batch(p, to);
        checks++;
        if (to || p != 20 || estoque !== 7'd59) begin
            errors++; $display("FAIL t4_setup: pulses=%0d timeout=%b estoque=%0d expected 20 0 59", p, to, estoque);
        end
        req = 1'b1; recarga = 1'b1;
        tick();
        recarga = 1'b0;
        checks++;
        if (estoque !== 7'd99 || ack !== 1'b0) begin
            errors++; $display("FAIL t4_priority: estoque=%0d ack=%b expected 99 0", estoque, ack);
        end
        tick();
        checks++;
        if (ack !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL t4_ack_next: ack=%b busy=%b expected 1 1", ack, busy);
        end
        wait_pulses(3, 200, p, fc, ac, ge, to);
        recarga = 1'b1;
        tick();
        recarga = 1'b0;
        checks++;
        if (to || p != 3 || estoque !== 7'd96) begin
            errors++; $display("FAIL t4_mid_recarga: pulses=%0d timeout=%b estoque=%0d expected 3 0 96", p, to, estoque);
        end
        wait_pulses(0, 200, p, fc, ac, ge, to);
        checks++;
        if (to || p != 17 || done !== 1'b1 || estoque !== 7'd79) begin
            errors++; $display("FAIL t4_end: pulses=%0d done=%b estoque=%0d expected 17 1 79", p, done, estoque);
        end
        req = 1'b0;
        tick();
    endtask

    task automatic test_clr_mid_batch();
        int p, fc, ac, ge;
        bit to;
        req = 1'b1;
        wait_pulses(12, 200, p, fc, ac, ge, to);
        tick();
        checks++;
        if (to || p != 12 || estoque !== 7'd67 || busy !== 1'b1) begin
            errors++; $display("FAIL t5_setup: pulses=%0d estoque=%0d busy=%b expected 12 67 1", p, estoque, busy);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if ({ack, busy, rolha, done, parcial} !== 5'b0 || estoque !== 7'd99) begin
            errors++; $display("FAIL t5_clr: outs=%b estoque=%0d expected 00000 99", {ack, busy, rolha, done, parcial}, estoque);
        end
        tick();
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL t5_reack: ack=%b expected 1", ack); end
        wait_pulses(0, 200, p, fc, ac, ge, to);
        checks++;
        if (to || p != 20 || fc != 1 || ge != 0 || estoque !== 7'd79 || done !== 1'b1) begin
            errors++; $display("FAIL t5_batch: pulses=%0d first=%0d gap_err=%0d estoque=%0d done=%b expected 20 1 0 79 1", p, fc, ge, estoque, done);
        end
        req = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL t5_release: done=%b expected 0", done); end
    endtask

    initial begin
        clr = 1'b1; enable = 1'b0; req = 1'b0; recarga = 1'b0;
        test_reset();
        test_full_batch();
        test_drain();
        test_enable_pause();
        test_recarga_priority();
        test_clr_mid_batch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
